// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// Master drives operands and start; slave returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders + OR)
// reused over WIDTH cycles, LSB first, with start/busy/done control.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  serial_add_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] s_sh, s_nx;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             c, co_q;
  logic             s, co;
  logic             h1_s, h1_c, h2_c;
  logic             accept, last;

  half_adder u_ha1 (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (h1_s),
    .c (h1_c)
  );

  half_adder u_ha2 (
    .x (h1_s),
    .y (c),
    .s (s),
    .c (h2_c)
  );

  assign co = h1_c | h2_c;

  // New bit enters at the MSB; also covers WIDTH == 1.
  assign s_nx = WIDTH'({s, s_sh} >> 1);

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = bus.start
                & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      s_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_nx;
      c    <= co;
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        sum_q <= s_nx;
        co_q  <= co;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;

endmodule

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder controller that time-shares one full-adder slice over WIDTH cycles, LSB first.
- The slice is built from two Half_Adder cell instances plus an OR gate, so the verified cell is reused rather than replicated per bit.
- Accepts operands with a start/busy/done handshake and presents a registered sum and carry-out.
- Used wherever area matters more than latency in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled on rising clk.
- a  input  WIDTH  operand A; sampled only in the cycle start is accepted.
- b  input  WIDTH  operand B; sampled only in the cycle start is accepted.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse when sum/carry_out become valid.
- sum  output  WIDTH  registered result, A+B mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at a rising edge) has priority over everything:
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry_out=0.
  - Internal shift registers, carry flop and counter are cleared.
  - Reset mid-operation discards the addition in progress; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> latch a and b into shift regs A_sh and B_sh, clear carry flop c, set cnt=0, go to RUN. start=0 -> stay in IDLE.
- RUN, each cycle: busy=1.
  - Slice computes s = A_sh[0]^B_sh[0]^c and co = majority(A_sh[0], B_sh[0], c) via HA1(A_sh[0], B_sh[0]), HA2(HA1.sum, c), co = HA1.carry | HA2.carry.
  - Shift A_sh and B_sh right by 1.
  - Shift s into the MSB of the result shift reg S_sh.
  - Set c <= co and cnt <= cnt+1.
  - When cnt==WIDTH-1 in this cycle: load sum <= the final S_sh value (including this cycle's bit), load carry_out <= co, and go to DONE.
- DONE (exactly one cycle): done=1, busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation): go to RUN.
  - Otherwise go to IDLE.
- Input handling:
  - start while in RUN is ignored: no restart, no effect on the result.
  - a and b are don't-care except in the accepting cycle; changes during RUN must not affect the result.
- Latency: if start is accepted at edge k, busy=1 from edge k through edge k+WIDTH, done=1 for the cycle after edge k+WIDTH, and sum/carry_out are valid from edge k+WIDTH.
  - Throughput: one addition per WIDTH+1 cycles.
- sum and carry_out:
  - Hold their last value through IDLE, DONE and the following RUN.
  - Change only at the completing edge or on reset.
- WIDTH=1: RUN lasts one cycle; the result equals a single full add with cin=0.
- Arithmetic: {carry_out, sum} == a + b exactly (WIDTH+1-bit result); no carry-in.

Test Plan:
- WIDTH=8, reset 2 cycles, then start with a=8'h0F, b=8'h01 -> busy high for 8 cycles; done pulses for 1 cycle at the 9th cycle after acceptance; sum=8'h10, carry_out=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1; with a=8'hFF, b=8'hFF -> sum=8'hFE, carry_out=1.
- Start a=8'h3C, b=8'h42, then on cycle 3 of RUN pulse start with a=8'h00, b=8'h00 and change a/b -> ignored; result sum=8'h7E, carry_out=0; exactly one done pulse.
- Assert rst during cycle 4 of RUN (a=8'hAA, b=8'h55) -> busy=0, done=0, sum=0, carry_out=0 on the next edge; no done pulse afterwards; a fresh start with a=8'h01, b=8'h02 yields sum=8'h03.
- Back-to-back: hold start=1 continuously with (8'h80, 8'h80) then (8'h12, 8'h34) -> first done gives sum=8'h00, carry_out=1; start is accepted in the DONE cycle; second done follows 9 cycles later with sum=8'h46, carry_out=0.
- Random regression: 1000 random a/b pairs at WIDTH=8 and WIDTH=1 -> {carry_out, sum} == a+b on every done; done never coincides with busy.
